// File: rtl/execute_md_pkg.sv
// execute_md_pkg: shared op and state encodings for the multiply/divide unit
package execute_md_pkg;
  typedef enum logic [2:0] {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU} op_t;
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
endpackage

// File: rtl/execute_md_if.sv
// execute_md_if: operation/result handshake and forwarding bus of the multiply/divide unit
interface execute_md_if #(parameter int XLEN = 32, parameter int FWD_PORTS = 2, parameter int REG_AW = 5);
  logic                        i_valid;
  logic                        o_ready;
  logic [2:0]                  i_op;
  logic [XLEN-1:0]             i_rs1_data;
  logic [XLEN-1:0]             i_rs2_data;
  logic [REG_AW-1:0]           i_rs1_addr;
  logic [REG_AW-1:0]           i_rs2_addr;
  logic [FWD_PORTS-1:0]        i_fwd_we;
  logic [FWD_PORTS*REG_AW-1:0] i_fwd_addr;
  logic [FWD_PORTS*XLEN-1:0]   i_fwd_data;
  logic                        i_flush;
  logic                        o_valid;
  logic                        i_ready;
  logic [XLEN-1:0]             o_result;
  logic [XLEN-1:0]             o_rs1_fwd_data;
  logic [XLEN-1:0]             o_rs2_fwd_data;
  modport master (
    output i_valid, i_op, i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr,
           i_fwd_we, i_fwd_addr, i_fwd_data, i_flush, i_ready,
    input  o_ready, o_valid, o_result, o_rs1_fwd_data, o_rs2_fwd_data
  );
  modport slave (
    input  i_valid, i_op, i_rs1_data, i_rs2_data, i_rs1_addr, i_rs2_addr,
           i_fwd_we, i_fwd_addr, i_fwd_data, i_flush, i_ready,
    output o_ready, o_valid, o_result, o_rs1_fwd_data, o_rs2_fwd_data
  );
endinterface

// File: rtl/execute_md_fwd_mux.sv
// fwd_mux: priority operand forwarding, lowest source index wins, x0 never forwarded
module fwd_mux #(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic [XLEN-1:0]             i_rf_data,
  input  logic [REG_AW-1:0]           i_rs_addr,
  input  logic [FWD_PORTS-1:0]        i_we,
  input  logic [FWD_PORTS*REG_AW-1:0] i_addr,
  input  logic [FWD_PORTS*XLEN-1:0]   i_data,
  output logic [XLEN-1:0]             o_data
);
  always_comb begin
    o_data = i_rf_data;
    for (int k = FWD_PORTS - 1; k >= 0; k--)
      if (i_we[k] && i_addr[k*REG_AW +: REG_AW] != '0 && i_addr[k*REG_AW +: REG_AW] == i_rs_addr)
        o_data = i_data[k*XLEN +: XLEN];
  end
endmodule

// File: rtl/execute_md.sv
// execute_md: iterative RV32M multiply/divide unit with operand forwarding
module execute_md import execute_md_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int FWD_PORTS = 2,
  parameter int REG_AW    = 5
) (
  input logic         i_clk,
  input logic         i_rst,
  execute_md_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  state_t            r_state, w_state_nx;
  op_t               r_op, w_op;
  logic [XLEN-1:0]   r_a, r_result, w_rs1, w_rs2, w_m1, w_m2, w_special, w_q, w_r, w_final;
  logic [2*XLEN-1:0] r_acc, w_mul_nx, w_div_nx, w_acc_nx, w_prod;
  logic [CW-1:0]     r_cnt;
  logic              r_neg_q, r_neg_r;
  logic              w_accept, w_s1, w_s2, w_n1, w_n2, w_dz, w_ovf, w_last, w_busy, w_ge;
  logic [XLEN:0]     w_mul_sum, w_rem_sh;
  logic [XLEN+1:0]   w_diff;
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_fwd1 (
    .i_rf_data(bus.i_rs1_data), .i_rs_addr(bus.i_rs1_addr), .i_we(bus.i_fwd_we),
    .i_addr(bus.i_fwd_addr), .i_data(bus.i_fwd_data), .o_data(w_rs1)
  );
  fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW), .FWD_PORTS(FWD_PORTS)) u_fwd2 (
    .i_rf_data(bus.i_rs2_data), .i_rs_addr(bus.i_rs2_addr), .i_we(bus.i_fwd_we),
    .i_addr(bus.i_fwd_addr), .i_data(bus.i_fwd_data), .o_data(w_rs2)
  );
  assign bus.o_rs1_fwd_data = w_rs1;
  assign bus.o_rs2_fwd_data = w_rs2;
  assign bus.o_ready        = r_state == S_IDLE;
  assign bus.o_valid        = r_state == S_DONE;
  assign bus.o_result       = r_result;
  // MUL is run unsigned: its low half is identical for signed operands
  always_comb begin
    w_op      = op_t'(bus.i_op);
    w_accept  = bus.i_valid && r_state == S_IDLE;
    w_s1      = w_op == OP_MULH || w_op == OP_MULHSU || w_op == OP_DIV || w_op == OP_REM;
    w_s2      = w_op == OP_MULH || w_op == OP_DIV || w_op == OP_REM;
    w_n1      = w_s1 && w_rs1[XLEN-1];
    w_n2      = w_s2 && w_rs2[XLEN-1];
    w_m1      = w_n1 ? -w_rs1 : w_rs1;
    w_m2      = w_n2 ? -w_rs2 : w_rs2;
    w_dz      = bus.i_op[2] && w_rs2 == '0;
    w_ovf     = bus.i_op[2] && !bus.i_op[0] && w_rs1 == {1'b1, {(XLEN-1){1'b0}}} && w_rs2 == '1;
    w_special = w_dz ? (bus.i_op[1] ? w_rs1 : '1) : (bus.i_op[1] ? '0 : w_rs1);
  end
  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    w_busy    = r_state == S_MUL || r_state == S_DIV;
    w_last    = r_cnt == CW'(XLEN - 1);
    w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : '0);
    w_mul_nx  = {w_mul_sum, r_acc[XLEN-1:1]};
    w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
    w_diff    = {1'b0, w_rem_sh} - {2'b0, r_a};
    w_ge      = !w_diff[XLEN+1];
    w_div_nx  = {w_ge ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], w_ge};
    w_acc_nx  = r_state == S_DIV ? w_div_nx : w_mul_nx;
    w_prod    = r_neg_q ? -w_mul_nx : w_mul_nx;
    w_q       = r_neg_q ? -w_div_nx[XLEN-1:0] : w_div_nx[XLEN-1:0];
    w_r       = r_neg_r ? -w_div_nx[2*XLEN-1:XLEN] : w_div_nx[2*XLEN-1:XLEN];
    w_final   = r_op == OP_MUL ? w_prod[XLEN-1:0] : !r_op[2] ? w_prod[2*XLEN-1:XLEN] : r_op[1] ? w_r : w_q;
  end
  always_comb begin
    w_state_nx = r_state;
    if (w_accept) w_state_nx = (w_dz || w_ovf) ? S_DONE : bus.i_op[2] ? S_DIV : S_MUL;
    if (w_busy && w_last) w_state_nx = S_DONE;
    if (r_state == S_DONE && bus.i_ready) w_state_nx = S_IDLE;
    if (bus.i_flush) w_state_nx = S_IDLE;
  end
  always_ff @(posedge i_clk)
    if (i_rst) r_state <= S_IDLE;
    else r_state <= w_state_nx;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      r_op     <= OP_MUL;
      r_a      <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (w_accept && !bus.i_flush) begin
      r_op    <= w_op;
      r_a     <= w_m2;
      r_acc   <= {{XLEN{1'b0}}, w_m1};
      r_cnt   <= '0;
      r_neg_q <= w_n1 ^ w_n2;
      r_neg_r <= w_n1;
      if (w_dz || w_ovf) r_result <= w_special;
    end else if (w_busy) begin
      r_acc <= w_acc_nx;
      r_cnt <= r_cnt + 1'b1;
      if (w_last) r_result <= w_final;
    end
endmodule

// File: tb/tb_execute_md.sv
// tb_execute_md: directed vectors with hand-computed results for execute_md
module tb_execute_md;
  import execute_md_pkg::*;
  logic clk, rst;
  int total, bad;
  execute_md_if #(.XLEN(32), .FWD_PORTS(2), .REG_AW(5)) bus ();
  execute_md #(.XLEN(32), .FWD_PORTS(2), .REG_AW(5)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic do_op(input string tag, input op_t op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat, input int hold);
    int lat;
    @(negedge clk);
    check({tag, "_rdy"}, 32'(bus.o_ready), 1);
    bus.i_valid = 1'b1;
    bus.i_op = op;
    bus.i_rs1_data = a;
    bus.i_rs2_data = b;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_rs1_data = 32'h1234_5678;
    bus.i_rs2_data = 32'h0BAD_F00D;
    bus.i_fwd_we = '0;
    lat = 1;
    while (!bus.o_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_res"}, bus.o_result, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_res"}, bus.o_result, exp);
      check({tag, "_hold_busy"}, {31'b0, bus.o_ready, bus.o_valid}, 32'b01);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
    check({tag, "_idle"}, {31'b0, bus.o_ready, bus.o_valid}, 32'b10);
  endtask
  task automatic start_abort(input string tag, input op_t op, input logic use_rst);
    logic seen;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_op = op;
    bus.i_rs1_data = 32'd100;
    bus.i_rs2_data = 32'd7;
    @(negedge clk);
    bus.i_valid = 1'b0;
    repeat (9) @(negedge clk);
    check({tag, "_busy"}, 32'(bus.o_ready), 0);
    if (use_rst) rst = 1'b1;
    else bus.i_flush = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.i_flush = 1'b0;
    check({tag, "_rdy"}, {31'b0, bus.o_ready, bus.o_valid}, 32'b10);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= bus.o_valid;
    end
    check({tag, "_novalid"}, 32'(seen), 0);
  endtask
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_op = '0;
    bus.i_rs1_data = '0;
    bus.i_rs2_data = '0;
    bus.i_rs1_addr = '0;
    bus.i_rs2_addr = '0;
    bus.i_fwd_we = '0;
    bus.i_fwd_addr = '0;
    bus.i_fwd_data = '0;
    bus.i_flush = 1'b0;
    bus.i_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hs", {31'b0, bus.o_ready, bus.o_valid}, 32'b10);
    check("rst_res", bus.o_result, 0);
    do_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 5);
    do_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 0);
    do_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33, 0);
    do_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33, 0);
    do_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 0);
    do_op("rem_dz", OP_REM, 32'd5, 32'd0, 32'd5, 1, 0);
    do_op("divu_dz", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("div_dz", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 0);
    do_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33, 0);
    do_op("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0);
    do_op("rem_neg", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0);
    do_op("divu_big", OP_DIVU, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 33, 0);
    @(negedge clk);
    bus.i_rs1_addr = 5'd3;
    bus.i_rs2_addr = 5'd0;
    bus.i_rs1_data = 32'h11;
    bus.i_rs2_data = 32'h55;
    bus.i_fwd_we = 2'b11;
    bus.i_fwd_addr = {5'd3, 5'd3};
    bus.i_fwd_data = {32'hB, 32'hA};
    #1 check("fwd_prio", bus.o_rs1_fwd_data, 32'hA);
    check("fwd_rf2", bus.o_rs2_fwd_data, 32'h55);
    bus.i_fwd_addr = {5'd0, 5'd0};
    bus.i_rs1_addr = 5'd0;
    #1 check("fwd_x0", bus.o_rs1_fwd_data, 32'h11);
    bus.i_rs1_addr = 5'd3;
    bus.i_rs2_addr = 5'd4;
    bus.i_fwd_addr = {5'd3, 5'd4};
    #1 check("fwd_one", bus.o_rs1_fwd_data, 32'hB);
    check("fwd_zero", bus.o_rs2_fwd_data, 32'hA);
    bus.i_fwd_we = 2'b00;
    #1 check("fwd_off", bus.o_rs1_fwd_data, 32'h11);
    bus.i_fwd_we = 2'b11;
    bus.i_fwd_addr = {5'd3, 5'd3};
    bus.i_rs2_addr = 5'd0;
    do_op("mul_fwd", OP_MUL, 32'h11, 32'd3, 32'd30, 33, 0);
    bus.i_rs1_addr = 5'd0;
    @(negedge clk);
    bus.i_valid = 1'b1;
    bus.i_flush = 1'b1;
    bus.i_op = OP_MUL;
    @(negedge clk);
    bus.i_valid = 1'b0;
    bus.i_flush = 1'b0;
    check("flush_acc", {31'b0, bus.o_ready, bus.o_valid}, 32'b10);
    start_abort("flush_div", OP_DIV, 1'b0);
    start_abort("rst_mul", OP_MUL, 1'b1);
    check("rst_mul_res", bus.o_result, 0);
    do_op("after", OP_MULHU, 32'h8000_0000, 32'd6, 32'd3, 33, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/execute_md.md
EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width.
REQ-002 SHALL have parameter FWD_PORTS, default 2, number of forwarding sources; index 0 is youngest and has highest priority.
REQ-003 SHALL have parameter REG_AW, default 5, register address width.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_valid  input  1  operation offered.
REQ-007 o_ready  output  1  block can accept an operation.
REQ-008 i_op  input  3  RV M-extension funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-009 i_rs1_data, i_rs2_data  input  XLEN each  register-file operands.
REQ-010 i_rs1_addr, i_rs2_addr  input  REG_AW each  source register numbers.
REQ-011 i_fwd_we  input  FWD_PORTS  per-source write enable.
REQ-012 i_fwd_addr  input  FWD_PORTS*REG_AW  per-source destination, flattened.
REQ-013 i_fwd_data  input  FWD_PORTS*XLEN  per-source data, flattened.
REQ-014 i_flush  input  1  kill any in-flight operation.
REQ-015 o_valid  output  1  result available.
REQ-016 i_ready  input  1  consumer takes the result.
REQ-017 o_result  output  XLEN  result.
REQ-018 o_rs1_fwd_data, o_rs2_fwd_data  output  XLEN each  operands after forwarding, for retire.

Function
REQ-019 Forwarding SHALL be combinational: for each operand, pick the lowest index k with we[k], addr[k]!=0 and addr[k]==rs_addr; otherwise use register-file data.
REQ-020 An operation SHALL be accepted on a cycle with i_valid & o_ready; forwarded operands and i_op SHALL be latched on that cycle only.
REQ-021 States SHALL be IDLE, MUL, DIV and DONE; o_ready=1 only in IDLE.
REQ-022 IDLE -> MUL on acceptance of a MUL* op; IDLE -> DIV on acceptance of a DIV*/REM* op, except for the special cases in REQ-025 and REQ-026.
REQ-023 MUL SHALL be shift-add, one bit per cycle on operand magnitudes, forming a 2*XLEN product, and SHALL transition to DONE after exactly XLEN cycles.
REQ-024 DIV SHALL be restoring radix-2 on magnitudes and SHALL transition to DONE after exactly XLEN cycles.
REQ-025 Divide by zero SHALL skip iteration and go IDLE -> DONE: quotient all-ones, remainder equals the dividend.
REQ-026 Signed overflow (most-negative / -1) SHALL go IDLE -> DONE: quotient most-negative, remainder 0.
REQ-027 Sign correction is applied at the final step.
  - product negative iff exactly one signed operand is negative (MULHSU: rs1 signed, rs2 unsigned).
  - quotient negative iff the operand signs differ; remainder takes the dividend's sign.
REQ-028 Result selection: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
REQ-029 Latency: o_valid SHALL rise XLEN+1 cycles after acceptance for iterative ops, and 1 cycle after for the special cases.
REQ-030 In DONE, o_valid=1 and o_result SHALL be held stable until i_valid... i.e. until i_ready=1; o_valid & i_ready -> IDLE on the next edge.
REQ-031 i_flush in any state SHALL force IDLE on the next edge with o_valid=0; a flush takes priority over acceptance and completion in the same cycle.
REQ-032 Back-to-back: a new operation is accepted no earlier than the cycle after the DONE handshake.

Reset
REQ-033 On i_rst: state IDLE, o_valid=0, o_result=0, iteration counter 0, all operand/accumulator registers 0; o_ready=1 from the first cycle after reset.
REQ-034 Reset mid-operation SHALL discard the operation with no result emitted.

Structure
REQ-035 A shared package SHALL hold the funct3 op encodings and the state encoding.
REQ-036 The forwarding priority selector SHALL be a sub-module fwd_mux, instantiated once per operand, parametrised by XLEN, REG_AW and FWD_PORTS.

Verification
REQ-037 MUL 7 x -3 -> o_result 0xFFFFFFEB, o_valid exactly 33 cycles after acceptance.
REQ-038 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH with the same operands -> 0x00000000.
REQ-039 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 one cycle later; REM 5 / 0 -> 5; DIVU 5 / 0 -> 0xFFFFFFFF.
REQ-040 rs1=x3 with fwd[0] and fwd[1] both writing x3 (data 0xA and 0xB) -> fwd[0] data (0xA) used; writes to x0 are never forwarded.
REQ-041 i_ready held low 5 cycles in DONE -> o_result stable and o_ready=0 throughout; handshake then returns to IDLE.
REQ-042 i_flush at iteration 10 of DIV -> o_valid never asserts and o_ready=1 on the next cycle; i_rst mid-MUL gives the same result.
